uart_rx_deserializer: RTL and testbench

Receive-side serial front end of the UART IP module. It synchronizes the asynchronous Rx pin, generates a 16x oversampling tick from a fractional baud divisor, frames each character, and checks its parity and stop bits. It delivers one 9-bit word per frame (8 data bits plus an error flag) with a single-cycle write strobe. It sits directly upstream of the UART receive FIFO and drives its DataIn and Write inputs.

---
 rtl/uart_rx_deserializer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: Rx synchronizer, fractional 16x tick generator, framing, parity/stop checks.
// Busy rises 3 clocks after the start edge; Write pulses 1 clock after the last stop sample; no backpressure.
module uart_rx_deserializer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Rx,
    input  logic [31:0] BaudDivisor,
    input  logic [1:0]  Size,
    input  logic        StopBits2,
    input  logic [1:0]  Parity,
    output logic [8:0]  DataOut,
    output logic        Write,
    output logic        Busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t      state, stateNext;
    logic        rxMeta, rxSync, rxPrev;
    logic [31:0] acc, accNext;
    logic [3:0]  tickCnt, tickCntNext;
    logic [2:0]  bitCnt, bitCntNext;
    logic [7:0]  data, dataNext;
    logic        frameErr, frameErrNext;
    logic        parityErr, parityErrNext;
    logic        feNow;
    logic [8:0]  dataOutNext;
    logic        writeNext;

    logic [31:0] brd;
    logic [32:0] accSum;
    logic        tick, midBit, startEdge, parityEn;
    logic [2:0]  lastBit;

    assign brd       = (BaudDivisor < 32'h100) ? 32'h100 : BaudDivisor;
    assign accSum    = {1'b0, acc} + 33'h100;
    assign tick      = accSum >= {1'b0, brd};
    // Mid-bit is the tick moving the counter from 7 to 8.
    assign midBit    = tick && (tickCnt == 4'd7);
    assign startEdge = rxPrev && !rxSync;
    assign lastBit   = 3'd4 + {1'b0, Size};
    assign parityEn  = (Parity == 2'b01) || (Parity == 2'b10);
    assign Busy      = (state != IDLE);

    always_comb begin
        stateNext     = state;
        accNext       = tick ? (accSum[31:0] - brd) : accSum[31:0];
        tickCntNext   = tick ? (tickCnt + 4'd1) : tickCnt;
        bitCntNext    = bitCnt;
        dataNext      = data;
        frameErrNext  = frameErr;
        parityErrNext = parityErr;
        feNow         = frameErr;
        dataOutNext   = DataOut;
        writeNext     = 1'b0;

        case (state)
            IDLE: begin
                accNext     = 32'd0;
                tickCntNext = 4'd0;
                if (startEdge && Enable) begin
                    stateNext     = START;
                    dataNext      = 8'd0;
                    frameErrNext  = 1'b0;
                    parityErrNext = 1'b0;
                end
            end
            START: begin
                if (midBit) begin
                    if (rxSync) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = DATA;
                        bitCntNext = 3'd0;
                    end
                end
            end
            DATA: begin
                if (midBit) begin
                    dataNext[bitCnt] = rxSync;
                    bitCntNext       = bitCnt + 3'd1;
                    if (bitCnt == lastBit) begin
                        stateNext = parityEn ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (midBit) begin
                    parityErrNext = ((^data) ^ rxSync) != (Parity == 2'b10);
                    stateNext     = STOP1;
                end
            end
            STOP1: begin
                if (midBit) begin
                    feNow        = !rxSync;
                    frameErrNext = feNow;
                    if (StopBits2) begin
                        stateNext = STOP2;
                    end else begin
                        stateNext   = IDLE;
                        dataOutNext = {feNow | parityErr, data};
                        writeNext   = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (midBit) begin
                    feNow        = frameErr | !rxSync;
                    frameErrNext = feNow;
                    stateNext    = IDLE;
                    dataOutNext  = {feNow | parityErr, data};
                    writeNext    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (!Enable) begin
            stateNext   = IDLE;
            writeNext   = 1'b0;
            dataOutNext = DataOut;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            rxPrev    <= 1'b1;
            acc       <= 32'd0;
            tickCnt   <= 4'd0;
            bitCnt    <= 3'd0;
            data      <= 8'd0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            DataOut   <= 9'd0;
            Write     <= 1'b0;
        end else begin
            state     <= stateNext;
            rxMeta    <= Rx;
            rxSync    <= rxMeta;
            rxPrev    <= rxSync;
            acc       <= accNext;
            tickCnt   <= tickCntNext;
            bitCnt    <= bitCntNext;
            data      <= dataNext;
            frameErr  <= frameErrNext;
            parityErr <= parityErrNext;
            DataOut   <= dataOutNext;
            Write     <= writeNext;
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames driven bit by bit, expected words and busy lengths hand-computed.
module tb_uart_rx_deserializer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b1;
    logic        Rx = 1'b1;
    logic [31:0] BaudDivisor = 32'h400;
    logic [1:0]  Size = 2'b11;
    logic        StopBits2 = 1'b0;
    logic [1:0]  Parity = 2'b00;
    logic [8:0]  DataOut;
    logic        Write;
    logic        Busy;

    int errors = 0;
    int checks = 0;

    int          writeTotal = 0;
    int          busyTotal = 0;
    int          protoErrs = 0;
    logic [8:0]  lastData = 9'h000;
    logic [8:0]  prevData;
    logic        prevWrite = 1'b0;
    logic        resetSeen = 1'b1;

    uart_rx_deserializer dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable(Enable),
        .Rx(Rx),
        .BaudDivisor(BaudDivisor),
        .Size(Size),
        .StopBits2(StopBits2),
        .Parity(Parity),
        .DataOut(DataOut),
        .Write(Write),
        .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Monitor: counts writes and busy cycles, flags DataOut changes outside Write and Write wider than 1 clock.
    always @(negedge Clock) begin
        if (Write === 1'b1) begin
            writeTotal = writeTotal + 1;
            lastData   = DataOut;
        end
        if (Busy === 1'b1) busyTotal = busyTotal + 1;
        if ((DataOut !== prevData) && (Write !== 1'b1) && !resetSeen) protoErrs = protoErrs + 1;
        if ((Write === 1'b1) && prevWrite) protoErrs = protoErrs + 1;
        prevData  = DataOut;
        prevWrite = (Write === 1'b1);
        resetSeen = (Reset === 1'b1);
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic sendFrame(input int cpb, input int nbits, input logic [7:0] dat,
                             input int parBit, input int nstop, input logic stopVal);
        logic [7:0] d;
        d = dat;
        Rx = 1'b0;
        waitClk(cpb);
        for (int i = 0; i < nbits; i++) begin
            Rx = d[i];
            waitClk(cpb);
        end
        if (parBit >= 0) begin
            Rx = parBit[0];
            waitClk(cpb);
        end
        for (int i = 0; i < nstop; i++) begin
            Rx = stopVal;
            waitClk(cpb);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        waitClk(3);
        checks++; if (DataOut !== 9'h000) begin errors++; $display("FAIL reset_dataout: got %h expected 000", DataOut); end
        checks++; if (Write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", Write); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        Reset = 1'b0;
        waitClk(10);
    endtask

    task automatic test_8n1;
        int w0, b0;
        w0 = writeTotal; b0 = busyTotal;
        fork
            sendFrame(64, 8, 8'hA5, -1, 1, 1'b1);
            begin
                waitClk(2);
                checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL start_busy_early: got %b expected 0", Busy); end
                waitClk(1);
                checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL start_busy_rise: got %b expected 1", Busy); end
            end
        join
        waitClk(20);
        checks++; if (writeTotal - w0 !== 1) begin errors++; $display("FAIL 8n1_writes: got %0d expected 1", writeTotal - w0); end
        checks++; if (lastData !== 9'h0A5) begin errors++; $display("FAIL 8n1_data: got %h expected 0a5", lastData); end
        checks++; if (busyTotal - b0 !== 608) begin errors++; $display("FAIL 8n1_busy_len: got %0d expected 608", busyTotal - b0); end
    endtask

    task automatic test_false_start;
        int w0, b0;
        w0 = writeTotal; b0 = busyTotal;
        Rx = 1'b0;
        waitClk(20);
        Rx = 1'b1;
        waitClk(80);
        checks++; if (busyTotal - b0 !== 32) begin errors++; $display("FAIL false_start_busy_len: got %0d expected 32", busyTotal - b0); end
        checks++; if (writeTotal - w0 !== 0) begin errors++; $display("FAIL false_start_writes: got %0d expected 0", writeTotal - w0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL false_start_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_framing_error;
        int w0;
        w0 = writeTotal;
        sendFrame(64, 8, 8'h3C, -1, 1, 1'b0);
        checks++; if (lastData !== 9'h13C) begin errors++; $display("FAIL fe_data: got %h expected 13c", lastData); end
        waitClk(3 * 640);
        checks++; if (writeTotal - w0 !== 1) begin errors++; $display("FAIL fe_held_low_writes: got %0d expected 1", writeTotal - w0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL fe_held_low_busy: got %b expected 0", Busy); end
        Rx = 1'b1;
        waitClk(64);
        sendFrame(64, 8, 8'h81, -1, 1, 1'b1);
        waitClk(20);
        checks++; if (lastData !== 9'h081) begin errors++; $display("FAIL fe_recover_data: got %h expected 081", lastData); end
    endtask

    task automatic test_parity;
        int w0, b0;
        Size = 2'b10; Parity = 2'b01; StopBits2 = 1'b1;
        w0 = writeTotal; b0 = busyTotal;
        sendFrame(64, 7, 8'h35, 0, 2, 1'b1);
        waitClk(20);
        checks++; if (lastData !== 9'h035) begin errors++; $display("FAIL 7e2_good_data: got %h expected 035", lastData); end
        checks++; if (busyTotal - b0 !== 672) begin errors++; $display("FAIL 7e2_busy_len: got %0d expected 672", busyTotal - b0); end
        sendFrame(64, 7, 8'h35, 1, 2, 1'b1);
        waitClk(20);
        checks++; if (lastData !== 9'h135) begin errors++; $display("FAIL 7e2_bad_parity: got %h expected 135", lastData); end
        checks++; if (writeTotal - w0 !== 2) begin errors++; $display("FAIL 7e2_writes: got %0d expected 2", writeTotal - w0); end
        Parity = 2'b10;
        sendFrame(64, 7, 8'h35, 1, 2, 1'b1);
        waitClk(20);
        checks++; if (lastData !== 9'h035) begin errors++; $display("FAIL 7o2_good_data: got %h expected 035", lastData); end
        sendFrame(64, 7, 8'h35, 0, 2, 1'b1);
        waitClk(20);
        checks++; if (lastData !== 9'h135) begin errors++; $display("FAIL 7o2_bad_parity: got %h expected 135", lastData); end
    endtask

    task automatic test_fractional;
        int w0, b0;
        Size = 2'b00; Parity = 2'b00; StopBits2 = 1'b0; BaudDivisor = 32'h00001B20;
        waitClk(5);
        w0 = writeTotal; b0 = busyTotal;
        sendFrame(434, 5, 8'h1F, -1, 1, 1'b1);
        waitClk(40);
        checks++; if (lastData !== 9'h01F) begin errors++; $display("FAIL frac_data: got %h expected 01f", lastData); end
        checks++; if (writeTotal - w0 !== 1) begin errors++; $display("FAIL frac_writes: got %0d expected 1", writeTotal - w0); end
        checks++; if (busyTotal - b0 !== 2821) begin errors++; $display("FAIL frac_busy_len: got %0d expected 2821", busyTotal - b0); end
    endtask

    task automatic test_abort;
        int w0;
        Size = 2'b11; BaudDivisor = 32'h400;
        waitClk(5);
        w0 = writeTotal;
        fork
            sendFrame(64, 8, 8'h00, -1, 1, 1'b1);
            begin
                waitClk(200);
                Enable = 1'b0;
                waitClk(1);
                checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL enable_abort_busy: got %b expected 0", Busy); end
            end
        join
        Enable = 1'b1;
        waitClk(30);
        checks++; if (writeTotal - w0 !== 0) begin errors++; $display("FAIL enable_abort_writes: got %0d expected 0", writeTotal - w0); end
        checks++; if (DataOut !== 9'h01F) begin errors++; $display("FAIL enable_abort_hold: got %h expected 01f", DataOut); end
        fork
            sendFrame(64, 8, 8'hC3, -1, 1, 1'b1);
            begin
                waitClk(200);
                Reset = 1'b1;
                waitClk(1);
                checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_abort_busy: got %b expected 0", Busy); end
                checks++; if (DataOut !== 9'h000) begin errors++; $display("FAIL reset_abort_data: got %h expected 000", DataOut); end
                checks++; if (Write !== 1'b0) begin errors++; $display("FAIL reset_abort_write: got %b expected 0", Write); end
            end
        join
        Reset = 1'b0;
        waitClk(30);
        checks++; if (writeTotal - w0 !== 0) begin errors++; $display("FAIL reset_abort_writes: got %0d expected 0", writeTotal - w0); end
        sendFrame(64, 8, 8'h5A, -1, 1, 1'b1);
        waitClk(20);
        checks++; if (lastData !== 9'h05A) begin errors++; $display("FAIL after_abort_data: got %h expected 05a", lastData); end
        checks++; if (writeTotal - w0 !== 1) begin errors++; $display("FAIL after_abort_writes: got %0d expected 1", writeTotal - w0); end
    endtask

    task automatic test_stability;
        checks++; if (protoErrs !== 0) begin errors++; $display("FAIL dataout_write_protocol: got %0d violations expected 0", protoErrs); end
    endtask

    initial begin
        waitClk(1);
        test_reset();
        test_8n1();
        test_false_start();
        test_framing_error();
        test_parity();
        test_fractional();
        test_abort();
        test_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
